// File: rtl/arbitre_ecriture.sv
// arbitre_ecriture: write-port owner for the register bank.
// Zero-fills every register after reset, then arbitrates writes between the
// pipeline writeback port (P, priority) and the load/debug port (L).
// Optional macro ARB_STARVE_GUARD_EN: bounds how long L can be held off by P.
module arbitre_ecriture #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              p_valid,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_ready,
  input  logic              l_valid,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_data,
  output logic              l_ready,
  output logic [ADDR_W-1:0] aW,
  output logic              W,
  output logic [DATA_W-1:0] DATA,
  output logic              busy
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic              p_xfer;
  logic              l_xfer;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             guard_hit;

  assign guard_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
`endif

  // Grant decode: depends on valids and state only, never on addr/data.
  always_comb begin
    p_ready = 1'b0;
    l_ready = 1'b0;
    if (state == RUN) begin
`ifdef ARB_STARVE_GUARD_EN
      if (guard_hit) begin
        l_ready = l_valid;
      end else begin
        p_ready = p_valid;
        l_ready = l_valid && !p_valid;
      end
`else
      p_ready = p_valid;
      l_ready = l_valid && !p_valid;
`endif
    end
  end

  assign p_xfer = p_valid && p_ready;
  assign l_xfer = l_valid && l_ready;

`ifdef ARB_STARVE_GUARD_EN
  // Counts P wins while L is waiting; saturates at the limit, cleared when L is served or idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      starve_cnt <= '0;
    end else if (state == RUN) begin
      if (l_xfer || !l_valid) begin
        starve_cnt <= '0;
      end else if (p_xfer && !guard_hit) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`endif

  // Init/run sequencer with registered bank write port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= INIT;
      init_ptr <= '0;
      aW       <= '0;
      W        <= 1'b0;
      DATA     <= '0;
      busy     <= 1'b1;
    end else if (state == INIT) begin
      aW       <= init_ptr;
      W        <= 1'b1;
      DATA     <= '0;
      init_ptr <= init_ptr + ADDR_W'(1);
      if (init_ptr == '1) begin
        state <= RUN;
        busy  <= 1'b0;
      end
    end else begin
      if (p_xfer) begin
        aW   <= p_addr;
        DATA <= p_data;
        W    <= 1'b1;
      end else if (l_xfer) begin
        aW   <= l_addr;
        DATA <= l_data;
        W    <= 1'b1;
      end else begin
        W <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbitre_ecriture.sv
// Bench for arbitre_ecriture: queued requesters, a transaction-level
// arbitration model and a shadow of the register bank.
module tb_arbitre_ecriture;

  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned DEPTH        = 16;
  localparam int unsigned STARVE_LIMIT = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              p_valid = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [DATA_W-1:0] p_data = '0;
  logic              p_ready;
  logic              l_valid = 1'b0;
  logic [ADDR_W-1:0] l_addr = '0;
  logic [DATA_W-1:0] l_data = '0;
  logic              l_ready;
  logic [ADDR_W-1:0] aW;
  logic              W;
  logic [DATA_W-1:0] DATA;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;

  req_t              pq[$];
  req_t              lq[$];
  logic [DATA_W-1:0] model_bank[DEPTH];
  logic [DATA_W-1:0] dut_bank[DEPTH];
  int                model_cnt = 0;
  logic [ADDR_W-1:0] exp_aw = '0;
  logic [DATA_W-1:0] exp_data = '0;

  arbitre_ecriture #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_ready(p_ready),
    .l_valid(l_valid), .l_addr(l_addr), .l_data(l_data), .l_ready(l_ready),
    .aW(aW), .W(W), .DATA(DATA), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the register bank: stores whatever the arbiter presents.
  always @(posedge CLK) if (W) dut_bank[aW] <= DATA;

  task automatic model_reset(input logic [ADDR_W-1:0] last_aw);
    pq.delete();
    lq.delete();
    model_cnt = 0;
    exp_aw    = last_aw;
    exp_data  = '0;
    for (int i = 0; i < DEPTH; i++) model_bank[i] = '0;
  endtask

  // One bus cycle: present queue heads, predict winner, sample ready and the registered write.
  task automatic step(output logic [14:0] obsv, output logic [14:0] expv);
    logic ep, el;
    p_valid = (pq.size() > 0);
    l_valid = (lq.size() > 0);
    if (p_valid) begin p_addr = pq[0].addr; p_data = pq[0].data; end
    else begin p_addr = ADDR_W'($urandom); p_data = DATA_W'($urandom); end
    if (l_valid) begin l_addr = lq[0].addr; l_data = lq[0].data; end
    else begin l_addr = ADDR_W'($urandom); l_data = DATA_W'($urandom); end
    ep = p_valid;
    el = l_valid && !p_valid;
`ifdef ARB_STARVE_GUARD_EN
    if (model_cnt == STARVE_LIMIT) begin ep = 1'b0; el = l_valid; end
`endif
    #2;
    obsv[14] = p_ready;
    obsv[13] = l_ready;
    if (ep) begin
      exp_aw = pq[0].addr; exp_data = pq[0].data; void'(pq.pop_front());
    end else if (el) begin
      exp_aw = lq[0].addr; exp_data = lq[0].data; void'(lq.pop_front());
    end
    if (ep || el) model_bank[exp_aw] = exp_data;
    if (el || !l_valid) model_cnt = 0;
    else if (ep && model_cnt < STARVE_LIMIT) model_cnt++;
    @(posedge CLK);
    #1;
    obsv[12:0] = {W, aW, DATA};
    expv = {ep, el, ep || el, exp_aw, exp_data};
    p_valid = 1'b0;
    l_valid = 1'b0;
  endtask

  task automatic wait_init();
    p_valid = 1'b0;
    l_valid = 1'b0;
    repeat (DEPTH) @(posedge CLK);
    #1;
    model_reset(ADDR_W'(DEPTH - 1));
  endtask

  task automatic test_reset();
    RST = 1'b0;
    p_valid = 1'b1;
    l_valid = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if ({p_ready, l_ready, W, aW, DATA, busy} !== {1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b%b W=%b aW=%0d DATA=%h busy=%b, want 00 0 0 00 1",
               p_ready, l_ready, W, aW, DATA, busy);
    end
  endtask

  task automatic test_init();
    logic [14:0] o, e;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      tests_run++;
      if ({p_ready, l_ready} !== 2'b00) begin
        tests_failed++;
        $display("FAIL init_ready[%0d]: got %b%b want 00", i, p_ready, l_ready);
      end
      @(posedge CLK);
      #1;
      tests_run++;
      if ({W, aW, DATA, busy} !== {1'b1, 4'(i), 8'd0, (i != DEPTH - 1)}) begin
        tests_failed++;
        $display("FAIL init_write[%0d]: got W=%b aW=%0d DATA=%h busy=%b want 1 %0d 00 %b",
                 i, W, aW, DATA, busy, i, (i != DEPTH - 1));
      end
    end
    p_valid = 1'b0;
    l_valid = 1'b0;
    model_reset(ADDR_W'(DEPTH - 1));
    step(o, e);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL init_idle: got %h want %h", o, e);
    end
    for (int a = 0; a < DEPTH; a++) begin
      tests_run++;
      if (dut_bank[a] !== 8'h00) begin
        tests_failed++;
        $display("FAIL init_bank[%0d]: got %h want 00", a, dut_bank[a]);
      end
    end
  endtask

  task automatic test_single_p();
    logic [14:0] o, e;
    pq.push_back('{addr: 4'd3, data: 8'hA5});
    step(o, e);
    tests_run++;
    if (o !== e || o !== {1'b1, 1'b0, 1'b1, 4'd3, 8'hA5}) begin
      tests_failed++;
      $display("FAIL single_p: got %h want %h", o, {1'b1, 1'b0, 1'b1, 4'd3, 8'hA5});
    end
    step(o, e);
    tests_run++;
    if (o !== e || W !== 1'b0 || dut_bank[3] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_p_after: got %h W=%b bank3=%h want %h W=0 bank3=a5", o, W, dut_bank[3], e);
    end
  endtask

  task automatic test_collision();
    logic [14:0] o, e;
    int pulses = 0;
    pq.push_back('{addr: 4'd5, data: 8'h11});
    lq.push_back('{addr: 4'd5, data: 8'h22});
    for (int i = 0; i < 3; i++) begin
      step(o, e);
      pulses += int'(o[12]);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL collision[%0d]: got %h want %h", i, o, e);
      end
    end
    tests_run++;
    if (pulses != 2 || dut_bank[5] !== 8'h22) begin
      tests_failed++;
      $display("FAIL collision_result: got pulses=%0d reg5=%h want 2 22", pulses, dut_bank[5]);
    end
  endtask

  task automatic test_l_alone();
    logic [14:0] o, e;
    for (int i = 1; i <= 3; i++) lq.push_back('{addr: 4'(i), data: 8'($urandom)});
    for (int i = 1; i <= 3; i++) begin
      step(o, e);
      tests_run++;
      if (o !== e || W !== 1'b1 || aW !== 4'(i)) begin
        tests_failed++;
        $display("FAIL l_alone[%0d]: got %h W=%b aW=%0d want %h W=1 aW=%0d", i, o, W, aW, e, i);
      end
    end
  endtask

  task automatic test_starve();
    logic [14:0] o, e;
    logic [ADDR_W-1:0] seq[8];
    int bound;
    req_t r;
    for (int i = 0; i < 12; i++) begin
      r.addr = 4'($urandom_range(0, 7));
      r.data = 8'($urandom);
      pq.push_back(r);
    end
    lq.push_back('{addr: 4'd9, data: 8'h3C});
    for (int i = 0; i < 8; i++) begin
      step(o, e);
      seq[i] = aW;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL starve_step[%0d]: got %h want %h", i, o, e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      logic want9;
`ifdef ARB_STARVE_GUARD_EN
      want9 = (i == STARVE_LIMIT);
`else
      want9 = 1'b0;
`endif
      tests_run++;
      if ((seq[i] == 4'd9) !== want9) begin
        tests_failed++;
        $display("FAIL starve_order[%0d]: got aW=%0d want L-write=%b", i, seq[i], want9);
      end
    end
    bound = 0;
    while ((pq.size() > 0 || lq.size() > 0) && bound < 30) begin
      step(o, e);
      bound++;
    end
    step(o, e);
    tests_run++;
    if (pq.size() != 0 || lq.size() != 0 || dut_bank[9] !== 8'h3C) begin
      tests_failed++;
      $display("FAIL starve_drain: got pq=%0d lq=%0d reg9=%h want 0 0 3c", pq.size(), lq.size(), dut_bank[9]);
    end
  endtask

  task automatic test_random();
    logic [14:0] o, e;
    int bad = 0;
    req_t r;
    for (int i = 0; i < 300 + 20; i++) begin
      if (i < 300) begin
        if (pq.size() < 3 && $urandom_range(0, 99) < 45) begin
          r.addr = ADDR_W'($urandom); r.data = DATA_W'($urandom); pq.push_back(r);
        end
        if (lq.size() < 3 && $urandom_range(0, 99) < 50) begin
          r.addr = ADDR_W'($urandom); r.data = DATA_W'($urandom); lq.push_back(r);
        end
      end
      step(o, e);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        bad++;
        if (bad < 10) $display("FAIL random[%0d]: got %h want %h", i, o, e);
      end
    end
    step(o, e);
    for (int a = 0; a < DEPTH; a++) begin
      tests_run++;
      if (dut_bank[a] !== model_bank[a]) begin
        tests_failed++;
        $display("FAIL random_bank[%0d]: got %h want %h", a, dut_bank[a], model_bank[a]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] o, e;
    int bound;
    // Mid-RUN with both requesters pending.
    pq.push_back('{addr: 4'd6, data: 8'h77});
    step(o, e);
    pq.push_back('{addr: 4'd7, data: 8'h88});
    lq.push_back('{addr: 4'd8, data: 8'h99});
    p_valid = 1'b1; p_addr = 4'd7; p_data = 8'h88;
    l_valid = 1'b1; l_addr = 4'd8; l_data = 8'h99;
    #2;
    RST = 1'b0;
    #1;
    tests_run++;
    if ({p_ready, l_ready, W, aW, DATA, busy} !== {1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_run: got rdy=%b%b W=%b aW=%0d DATA=%h busy=%b want 00 0 0 00 1",
               p_ready, l_ready, W, aW, DATA, busy);
    end
    p_valid = 1'b0;
    l_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    tests_run++;
    if ({W, aW, DATA} !== {1'b1, 4'd0, 8'd0}) begin
      tests_failed++;
      $display("FAIL restart_run: got W=%b aW=%0d DATA=%h want 1 0 00", W, aW, DATA);
    end
    // Mid-INIT, right after address 7 was presented.
    bound = 0;
    while (aW !== 4'd7 && bound < 20) begin
      @(posedge CLK);
      #1;
      bound++;
    end
    #2;
    RST = 1'b0;
    #1;
    tests_run++;
    if (bound >= 20 || {p_ready, l_ready, W, aW, DATA, busy} !== {1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_init: got bound=%0d W=%b aW=%0d DATA=%h busy=%b want W=0 aW=0 busy=1",
               bound, W, aW, DATA, busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    tests_run++;
    if ({W, aW, busy} !== {1'b1, 4'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL restart_init: got W=%b aW=%0d busy=%b want 1 0 1", W, aW, busy);
    end
    repeat (DEPTH - 1) @(posedge CLK);
    #1;
    model_reset(ADDR_W'(DEPTH - 1));
    tests_run++;
    if ({busy, aW} !== {1'b0, 4'd15}) begin
      tests_failed++;
      $display("FAIL restart_done: got busy=%b aW=%0d want 0 15", busy, aW);
    end
    step(o, e);
    for (int a = 0; a < DEPTH; a++) begin
      tests_run++;
      if (dut_bank[a] !== 8'h00) begin
        tests_failed++;
        $display("FAIL restart_bank[%0d]: got %h want 00", a, dut_bank[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_p();
    test_collision();
    test_l_alone();
    test_starve();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
